adaptive_filter_out_framer: RTL

- Downstream stage of the adaptive filter.
- Consumes the filter's free-running 14-bit output sample and its mode line (ctrl: 1 = integrator, 0 = differentiator).
- Discards samples while the filter pipeline settles after reset or a mode change, then rounds and saturates each sample to OUT_WIDTH.
- Buffers samples in a FIFO and presents them as an AXI-Stream master in fixed-length frames, with tlast and a per-sample mode/pad tag.

---
 rtl/adaptive_filter_out_framer_if.sv | 19 +
 rtl/adaptive_filter_out_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_filter_out_framer_if.sv
// AXI-Stream style bus carrying framed output samples of the adaptive filter.
//   tdata  : signed output sample, OUT_WIDTH bits
//   tvalid : sample valid
//   tready : sink ready
//   tlast  : last sample of a frame
//   tuser  : [0] filter mode of the sample, [1] pad sample
// master modport drives the bus, slave modport consumes it.
interface adaptive_filter_out_framer_if #(
    parameter int unsigned OUT_WIDTH = 12
) ();
    logic [OUT_WIDTH-1:0] tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;
    logic [1:0]           tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/adaptive_filter_out_framer.sv
// Output framer of the adaptive filter. Discards samples while the filter settles after
// reset or a mode change, rounds/saturates each 14-bit sample to OUT_WIDTH, buffers it in a
// FIFO and emits fixed FRAME_LEN frames on an AXI-Stream master. A mode change mid-frame
// completes the frame with zero pad samples.
// Ports:
//   clk, srst   : clock, synchronous active-high reset
//   ctrl        : filter mode (1 = integrator, 0 = differentiator), aligned with s_tdata
//   s_tdata     : signed filter output, valid every cycle
//   m           : AXI-Stream master (tdata, tvalid, tready, tlast, tuser)
//   ovf         : sticky, a sample was dropped because the FIFO was full
//   frame_cnt   : frames delivered, saturating (ADAPTIVE_FILTER_FRAMER_STATS_EN only)
//   drop_cnt    : samples dropped, saturating (ADAPTIVE_FILTER_FRAMER_STATS_EN only)
// Optional statistics are built when the macro ADAPTIVE_FILTER_FRAMER_STATS_EN is defined.
module adaptive_filter_out_framer #(
    parameter int unsigned OUT_WIDTH     = 12,
    parameter int unsigned FRAME_LEN     = 32,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic                                ctrl,
    input  logic [13:0]                         s_tdata,
    adaptive_filter_out_framer_if.master        m,
    output logic                                ovf
`ifdef ADAPTIVE_FILTER_FRAMER_STATS_EN
    ,
    output logic [15:0]                         frame_cnt,
    output logic [15:0]                         drop_cnt
`endif
);

    localparam int unsigned Shift = 14 - OUT_WIDTH;
    localparam int unsigned FcntW = $clog2(FRAME_LEN);
    localparam int unsigned PadW  = $clog2(FRAME_LEN + 1);
    localparam int unsigned SetW  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = AddrW + 1;
    localparam int unsigned EntW  = OUT_WIDTH + 3;

    localparam logic [FcntW-1:0] FcntLast   = FcntW'(FRAME_LEN - 1);
    localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0]  FullCount  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StSettle, StRun, StPad} state_e;

    state_e               state_q;
    logic                 ctrl_q;
    logic [SetW-1:0]      settle_q;
    logic [FcntW-1:0]     fcnt_q;
    logic [PadW-1:0]      pad_rem_q;
    logic                 pad_mode_q;
    logic                 ovf_q;

    // One-entry stage between the sample decision and the FIFO write.
    logic                 stg_valid_q;
    logic                 stg_pad_q;
    logic                 stg_mode_q;
    logic [OUT_WIDTH-1:0] stg_data_q;

    // Entry layout: {pad, mode, last, data}.
    logic [EntW-1:0]      mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]     wr_ptr_q;
    logic [AddrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic                 chg;
    logic                 out_valid;
    logic                 rd;
    logic                 room;
    logic                 wr;
    logic                 drop;
    logic                 stg_free;
    logic                 last_slot;
    logic [FcntW-1:0]     fcnt_nxt;
    logic [EntW-1:0]      head;
    logic [OUT_WIDTH-1:0] rnd_val;

    // Round half up, then saturate to the signed OUT_WIDTH range.
    if (Shift == 0) begin : g_pass
        assign rnd_val = s_tdata;
    end else begin : g_round
        localparam logic signed [14:0] Half = 15'sd1 <<< (Shift - 1);
        localparam logic signed [14:0] MaxV = (15'sd1 <<< (OUT_WIDTH - 1)) - 15'sd1;
        localparam logic signed [14:0] MinV = -(15'sd1 <<< (OUT_WIDTH - 1));
        logic signed [14:0] sum;
        logic signed [14:0] shr;
        assign sum = $signed({s_tdata[13], s_tdata}) + Half;
        assign shr = sum >>> Shift;
        always_comb begin
            rnd_val = shr[OUT_WIDTH-1:0];
            if (shr > MaxV) begin
                rnd_val = MaxV[OUT_WIDTH-1:0];
            end else if (shr < MinV) begin
                rnd_val = MinV[OUT_WIDTH-1:0];
            end
        end
    end

    assign chg       = ctrl ^ ctrl_q;
    assign out_valid = (count_q != '0);
    assign rd        = out_valid & m.tready;
    assign room      = (count_q != FullCount) | rd;
    assign wr        = stg_valid_q & room;
    // Only run samples are dropped; pad entries wait for room.
    assign drop      = stg_valid_q & ~stg_pad_q & ~room;
    assign stg_free  = ~(stg_valid_q & stg_pad_q & ~room);
    assign last_slot = (fcnt_q == FcntLast);

    // Frame position as it stands after this cycle's write.
    always_comb begin
        fcnt_nxt = fcnt_q;
        if (wr) begin
            fcnt_nxt = last_slot ? '0 : fcnt_q + FcntW'(1);
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign m.tvalid = out_valid;
    assign m.tdata  = out_valid ? head[OUT_WIDTH-1:0] : '0;
    assign m.tlast  = out_valid & head[OUT_WIDTH];
    assign m.tuser  = out_valid ? head[EntW-1:EntW-2] : 2'b00;
    assign ovf      = ovf_q;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= {stg_pad_q, stg_mode_q, last_slot, stg_data_q};
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= StSettle;
            ctrl_q      <= ctrl;
            settle_q    <= SettleLoad;
            fcnt_q      <= '0;
            pad_rem_q   <= '0;
            pad_mode_q  <= 1'b0;
            ovf_q       <= 1'b0;
            stg_valid_q <= 1'b0;
            stg_pad_q   <= 1'b0;
            stg_mode_q  <= 1'b0;
            stg_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            ctrl_q <= ctrl;
            fcnt_q <= fcnt_nxt;
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            case ({wr, rd})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (stg_free) begin
                stg_valid_q <= 1'b0;
            end

            unique case (state_q)
                StSettle: begin
                    if (chg) begin
                        settle_q <= SettleLoad;
                    end else begin
                        settle_q <= settle_q - SetW'(1);
                        if (settle_q == SetW'(1)) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (chg) begin
                        if (fcnt_nxt == '0) begin
                            state_q  <= StSettle;
                            settle_q <= SettleLoad;
                        end else begin
                            state_q    <= StPad;
                            pad_rem_q  <= PadW'(FRAME_LEN) - PadW'(fcnt_nxt);
                            // Pads carry the mode of the frame they complete.
                            pad_mode_q <= ctrl_q;
                        end
                    end else begin
                        stg_valid_q <= 1'b1;
                        stg_pad_q   <= 1'b0;
                        stg_mode_q  <= ctrl;
                        stg_data_q  <= rnd_val;
                    end
                end
                StPad: begin
                    // Leave only once the final pad has reached the FIFO.
                    if (stg_free) begin
                        if (pad_rem_q != '0) begin
                            stg_valid_q <= 1'b1;
                            stg_pad_q   <= 1'b1;
                            stg_mode_q  <= pad_mode_q;
                            stg_data_q  <= '0;
                            pad_rem_q   <= pad_rem_q - PadW'(1);
                        end else begin
                            state_q  <= StSettle;
                            settle_q <= SettleLoad;
                        end
                    end
                end
                default: state_q <= StSettle;
            endcase
        end
    end

`ifdef ADAPTIVE_FILTER_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (srst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (rd && head[OUT_WIDTH] && frame_cnt != 16'hffff) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop && drop_cnt != 16'hffff) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
